// File: rtl/fp_seq_pkg.sv
// rtl/fp_seq_pkg.sv - shared opcode/state enums and lane width for the FP sequencer
package fp_seq_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    FP_ADD = 2'b00,
    FP_SUB = 2'b01,
    FP_MUL = 2'b10,
    FP_CMP = 2'b11
  } fp_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } seq_state_e;

endpackage

// File: rtl/fp_vec_seq.sv
// rtl/fp_vec_seq.sv - vector FP operation sequencer, one lane per cycle into an external FP ALU
// Optional reduction mode (req_reduce port, accumulator) under FP_SEQ_REDUCE_EN.
module fp_vec_seq
  import fp_seq_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int DATA_W    = fp_seq_pkg::DATA_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [1:0]                    req_op,
  input  logic [NUM_LANES*DATA_W-1:0]   req_a,
  input  logic [NUM_LANES*DATA_W-1:0]   req_b,
`ifdef FP_SEQ_REDUCE_EN
  input  logic                          req_reduce,
`endif
  output logic [DATA_W-1:0]             alu_a,
  output logic [DATA_W-1:0]             alu_b,
  output logic [1:0]                    alu_op,
  input  logic [DATA_W-1:0]             alu_out,
  input  logic                          alu_gt,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [NUM_LANES*DATA_W-1:0]   rsp_vec,
  output logic [NUM_LANES-1:0]          rsp_mask
);

  localparam int IDX_W = $clog2(NUM_LANES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LANES - 1);

  seq_state_e                  r_state, w_next;
  fp_op_e                      r_op;
  logic [NUM_LANES*DATA_W-1:0] r_a, r_b;
  logic [DATA_W-1:0]           r_res [NUM_LANES];
  logic [NUM_LANES-1:0]        r_mask;
  logic [IDX_W-1:0]            r_idx;
  logic [DATA_W-1:0]           w_a [NUM_LANES];
  logic [DATA_W-1:0]           w_b [NUM_LANES];
  logic                        w_accept, w_last;
`ifdef FP_SEQ_REDUCE_EN
  logic                        r_reduce;
  logic [DATA_W-1:0]           r_acc;
`endif

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign w_a[g] = r_a[DATA_W*g +: DATA_W];
    assign w_b[g] = r_b[DATA_W*g +: DATA_W];
    assign rsp_vec[DATA_W*g +: DATA_W] = r_res[g];
  end
  assign rsp_mask = r_mask;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    alu_a     = '0;
    alu_b     = '0;
    alu_op    = '0;
    w_accept  = 1'b0;
    w_last    = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = !rst;
        w_accept  = req_valid && !rst;
        if (w_accept) w_next = RUN;
      end
      RUN: begin
        alu_op = r_op;
`ifdef FP_SEQ_REDUCE_EN
        if (r_reduce) begin
          alu_a = r_acc;
          alu_b = w_a[r_idx];
        end else
`endif
        begin
          alu_a = w_a[r_idx];
          alu_b = w_b[r_idx];
        end
        w_last = (r_idx == LAST_IDX);
        if (w_last) w_next = DONE;
      end
      DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Reduction starts at lane 1: lane 0 seeds the accumulator at accept time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op   <= FP_ADD;
      r_a    <= '0;
      r_b    <= '0;
      r_mask <= '0;
      r_idx  <= '0;
      for (int i = 0; i < NUM_LANES; i++) r_res[i] <= '0;
`ifdef FP_SEQ_REDUCE_EN
      r_reduce <= 1'b0;
      r_acc    <= '0;
`endif
    end else if (w_accept) begin
      r_op   <= fp_op_e'(req_op);
      r_a    <= req_a;
      r_b    <= req_b;
      r_mask <= '0;
      r_idx  <= '0;
      for (int i = 0; i < NUM_LANES; i++) r_res[i] <= '0;
`ifdef FP_SEQ_REDUCE_EN
      r_reduce <= req_reduce && (req_op != FP_CMP);
      r_acc    <= req_a[DATA_W-1:0];
      if (req_reduce && (req_op != FP_CMP)) r_idx <= IDX_W'(1);
`endif
    end else if (r_state == RUN) begin
`ifdef FP_SEQ_REDUCE_EN
      if (r_reduce) begin
        r_acc <= alu_out;
        if (w_last) r_res[0] <= alu_out;
      end else
`endif
      begin
        r_res[r_idx]  <= alu_out;
        r_mask[r_idx] <= (r_op == FP_CMP) && alu_gt;
      end
      if (!w_last) r_idx <= r_idx + IDX_W'(1);
    end
  end

endmodule

// File: tb/tb_fp_vec_seq.sv
// tb/tb_fp_vec_seq.sv - self-checking bench for fp_vec_seq with a behavioural FP ALU stand-in
module tb_fp_vec_seq;

  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           req_valid = 1'b0;
  logic           req_ready;
  logic [1:0]     req_op = 2'b00;
  logic [N*W-1:0] req_a = '0;
  logic [N*W-1:0] req_b = '0;
  logic           req_reduce = 1'b0;
  logic [W-1:0]   alu_a, alu_b, alu_out;
  logic [1:0]     alu_op;
  logic           alu_gt;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [N*W-1:0] rsp_vec;
  logic [N-1:0]   rsp_mask;

  int n_cmp = 0;
  int n_fail = 0;

  fp_vec_seq #(.NUM_LANES(N), .DATA_W(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
`ifdef FP_SEQ_REDUCE_EN
    .req_reduce(req_reduce),
`endif
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .alu_gt(alu_gt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_vec(rsp_vec), .rsp_mask(rsp_mask)
  );

  always #5 clk = ~clk;

  // Normal numbers and zero only; stimulus keeps values small integers so results are exact.
  function automatic real sp2r(input logic [31:0] x);
    logic [63:0] d;
    if (x[30:0] == 31'd0) d = {x[31], 63'd0};
    else d = {x[31], 11'(int'(x[30:23]) - 127 + 1023), x[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2sp(input real r);
    logic [63:0] d;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return 32'd0;
    return {d[63], 8'(int'(d[62:52]) - 1023 + 127), d[51:29]};
  endfunction

  function automatic logic [31:0] fp_calc(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] op);
    case (op)
      2'b00:   return r2sp(sp2r(a) + sp2r(b));
      2'b01:   return r2sp(sp2r(a) - sp2r(b));
      2'b10:   return r2sp(sp2r(a) * sp2r(b));
      default: return b;
    endcase
  endfunction

  always_comb begin
    alu_out = fp_calc(alu_a, alu_b, alu_op);
    alu_gt  = sp2r(alu_a) > sp2r(alu_b);
  end

  function automatic logic [N*W-1:0] pack4(input logic [31:0] l0, input logic [31:0] l1,
                                           input logic [31:0] l2, input logic [31:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  function automatic logic [N*W-1:0] rand_vec();
    logic [N*W-1:0] v;
    for (int i = 0; i < N; i++) v[W*i +: W] = r2sp(real'($urandom_range(1, 16)));
    return v;
  endfunction

  task automatic chk(input string tag, input logic [N*W-1:0] obs, input logic [N*W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_rsp_valid"}, N*W'(rsp_valid), '0);
    chk({tag, "_rsp_vec"}, rsp_vec, '0);
    chk({tag, "_rsp_mask"}, N*W'(rsp_mask), '0);
    chk({tag, "_alu_a"}, N*W'(alu_a), '0);
    chk({tag, "_alu_b"}, N*W'(alu_b), '0);
    chk({tag, "_alu_op"}, N*W'(alu_op), '0);
  endtask

  task automatic accept(input logic [1:0] op, input logic [N*W-1:0] a,
                        input logic [N*W-1:0] b, input logic red);
    int t;
    t = 0;
    while (req_ready !== 1'b1 && t < 20) begin
      @(posedge clk); #1; t++;
    end
    chk("accept_wait", N*W'(req_ready), N*W'(1));
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_reduce = red;
    @(posedge clk); #1;
    req_valid = 1'b0; req_reduce = 1'b0;
  endtask

  // Reference: lane-wise op, or left fold of A for a non-compare reduction.
  task automatic collect(input logic [1:0] op, input logic [N*W-1:0] a,
                         input logic [N*W-1:0] b, input logic red, input int hold,
                         input logic early_rdy,
                         output logic [N*W-1:0] got_vec, output logic [N-1:0] got_mask);
    logic [N*W-1:0] exp_vec;
    logic [N-1:0]   exp_mask;
    logic [31:0]    acc;
    int             lat, c;
    logic           do_red;
    do_red   = red && (op != 2'b11);
    exp_vec  = '0;
    exp_mask = '0;
    if (do_red) begin
      acc = a[W-1:0];
      for (int i = 1; i < N; i++) acc = fp_calc(acc, a[W*i +: W], op);
      exp_vec[W-1:0] = acc;
      lat = N - 1;
    end else begin
      for (int i = 0; i < N; i++) begin
        exp_vec[W*i +: W] = fp_calc(a[W*i +: W], b[W*i +: W], op);
        exp_mask[i] = (op == 2'b11) && (sp2r(a[W*i +: W]) > sp2r(b[W*i +: W]));
      end
      lat = N;
    end
    rsp_ready = early_rdy;
    c = 0;
    while (rsp_valid !== 1'b1 && c < 40) begin
      chk("run_alu_op", N*W'(alu_op), N*W'(op));
      chk("run_req_ready", N*W'(req_ready), '0);
      @(posedge clk); #1; c++;
    end
    rsp_ready = 1'b0;
    chk("latency", N*W'(c), N*W'(lat));
    chk("rsp_vec", rsp_vec, exp_vec);
    chk("rsp_mask", N*W'(rsp_mask), N*W'(exp_mask));
    got_vec  = rsp_vec;
    got_mask = rsp_mask;
    for (int h = 0; h < hold; h++) begin
      req_valid = 1'b1; req_op = 2'b10; req_a = rand_vec(); req_b = rand_vec();
      @(posedge clk); #1;
      chk("hold_rsp_valid", N*W'(rsp_valid), N*W'(1));
      chk("hold_req_ready", N*W'(req_ready), '0);
      chk("hold_vec", rsp_vec, exp_vec);
      chk("hold_mask", N*W'(rsp_mask), N*W'(exp_mask));
      chk("hold_alu_op", N*W'(alu_op), '0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("post_rsp_valid", N*W'(rsp_valid), '0);
    chk("post_req_ready", N*W'(req_ready), N*W'(1));
    chk("post_alu_op", N*W'(alu_op), '0);
  endtask

  initial begin
    logic [N*W-1:0] a, b, gv;
    logic [N-1:0]   gm;
    logic [1:0]     op;

    #1;
    chk("reset_req_ready", N*W'(req_ready), '0);
    chk_idle_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("idle_req_ready", N*W'(req_ready), N*W'(1));

    // Add
    a = pack4(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000);
    b = pack4(32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000);
    accept(2'b00, a, b, 1'b0);
    collect(2'b00, a, b, 1'b0, 0, 1'b0, gv, gm);
    chk("add_const_vec", gv, pack4(32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000));
    chk("add_const_mask", N*W'(gm), '0);

    // Compare, with 5-cycle backpressure
    a = pack4(32'h3F800000, 32'h40800000, 32'h40000000, 32'h41000000);
    b = pack4(32'h40000000, 32'h40400000, 32'h40000000, 32'h3F800000);
    accept(2'b11, a, b, 1'b0);
    collect(2'b11, a, b, 1'b0, 5, 1'b0, gv, gm);
    chk("cmp_const_mask", N*W'(gm), N*W'(4'b1010));
    chk("cmp_const_vec", gv, b);

    // Reset mid-RUN after two lanes of a mul
    a = pack4(32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000);
    b = pack4(32'h40400000, 32'h40400000, 32'h40400000, 32'h40400000);
    accept(2'b10, a, b, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrun_req_ready", N*W'(req_ready), '0);
    chk_idle_outputs("midrun");
    @(posedge clk); #1;
    rst = 1'b0;
    a = pack4(32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000);
    accept(2'b10, a, b, 1'b0);
    collect(2'b10, a, b, 1'b0, 1, 1'b0, gv, gm);
    chk("mul_const_vec", gv, pack4(32'h40C00000, 32'h40C00000, 32'h40C00000, 32'h40C00000));

    // Sub to zero; rsp_ready held high during RUN must not matter
    a = pack4(32'h40A00000, 32'h40A00000, 32'h40A00000, 32'h40A00000);
    accept(2'b01, a, a, 1'b0);
    collect(2'b01, a, a, 1'b0, 0, 1'b1, gv, gm);
    chk("sub_zero_vec", gv, '0);

`ifdef FP_SEQ_REDUCE_EN
    a = pack4(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000);
    accept(2'b10, a, b, 1'b1);
    collect(2'b10, a, b, 1'b1, 0, 1'b0, gv, gm);
    chk("reduce_mul_vec", gv, pack4(32'h41C00000, 32'h0, 32'h0, 32'h0));
    accept(2'b11, a, b, 1'b1);
    collect(2'b11, a, b, 1'b1, 0, 1'b0, gv, gm);
`endif

    for (int t = 0; t < 12; t++) begin
      op = 2'($urandom_range(0, 3));
      a  = rand_vec();
      b  = rand_vec();
`ifdef FP_SEQ_REDUCE_EN
      req_reduce = 1'($urandom_range(0, 1));
`endif
      begin
        logic red;
        red = req_reduce;
        accept(op, a, b, red);
        collect(op, a, b, red, $urandom_range(0, 3), 1'($urandom_range(0, 1)), gv, gm);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_vec_seq.md
# fp_vec_seq

Multi-lane floating-point operation sequencer: the initiator side of the FP ALU operand/result interface. It accepts a vector request of up to NUM_LANES single-precision operand pairs through a valid/ready handshake and drives one lane per cycle onto the combinational FP ALU's A/B/op inputs. It captures the ALU's `out` and `gt` each cycle and returns a packed result vector and compare mask through a second valid/ready handshake. It sits between the vector issue logic and the FP ALU instance in the parent execution unit.

## Interface
- NUM_LANES, 4, lanes per request (≥2)
- DATA_W, 32, lane width (IEEE-754 single)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request valid
- req_ready  out  1  sequencer can accept a request
- req_op  in  2  00 add, 01 sub, 10 mul, 11 compare
- req_a  in  NUM_LANES*DATA_W  operand A vector; lane i at [DATA_W*i +: DATA_W]
- req_b  in  NUM_LANES*DATA_W  operand B vector, same packing
- req_reduce  in  1  reduction request (present only with FP_SEQ_REDUCE_EN)
- alu_a, alu_b  out  DATA_W  operands to FP ALU
- alu_op  out  2  opcode to FP ALU
- alu_out  in  DATA_W  ALU result (combinational from alu_a/alu_b/alu_op)
- alu_gt  in  1  ALU compare result
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_vec  out  NUM_LANES*DATA_W  result vector, same packing
- rsp_mask  out  NUM_LANES  compare mask; bit i = lane i

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- IDLE: req_ready=1. On req_valid&&req_ready, latch req_a/req_b/req_op (and req_reduce), clear lane index, clear result and mask registers, go to RUN.
- RUN: drive alu_a=A[idx], alu_b=B[idx], alu_op=op. At the clock edge, capture res[idx]←alu_out, mask[idx]←alu_gt when op==11, otherwise 0. Then idx++. After capturing lane NUM_LANES-1 → DONE.
- DONE: rsp_valid=1 and rsp_vec/rsp_mask held stable. On rsp_ready → IDLE.
- req_ready is high only in IDLE. A request presented in any other state is ignored and must be held by the requester.
- Outside RUN, alu_a/alu_b/alu_op are driven to 0.
- For compare, the ALU returns operand B on `out`, so rsp_vec equals req_b.
- Lane index width is $clog2(NUM_LANES); no wrap beyond NUM_LANES-1.

## Timing
- Reset values: req_ready=0 while rst is high and 1 in IDLE afterwards; rsp_valid=0; rsp_vec=0; rsp_mask=0; alu_a/alu_b/alu_op=0; idx=0.
- Accept at edge E. Lane i is captured at edge E+1+i. rsp_valid rises after edge E+NUM_LANES.
- Response handshake completes at the edge where rsp_valid&&rsp_ready. req_ready rises after that edge, which gives a one-cycle bubble between requests.
- Reset asserted mid-RUN or in DONE: the operation is discarded immediately and all outputs take their reset values. No partial response is ever issued.
- rsp_ready high before DONE has no effect.

## Configuration
- FP_SEQ_REDUCE_EN defined: the req_reduce port exists and reduction mode is supported.
  - When a request is accepted with req_reduce=1, the accumulator is loaded with A[0].
  - For i=1..NUM_LANES-1: alu_a=acc, alu_b=A[i], alu_op=op, acc←alu_out. This takes NUM_LANES-1 RUN cycles.
  - Response: lane 0 = acc, other lanes 0, mask 0.
  - req_reduce with op 11 is ignored and the request runs elementwise.
- FP_SEQ_REDUCE_EN undefined: the port is absent, there is no accumulator, and only elementwise operation is supported.

## Structure
- Shared package fp_seq_pkg holds:
  - the opcode enum: FP_ADD=00, FP_SUB=01, FP_MUL=10, FP_CMP=11 (shared with the FP ALU users)
  - the state enum: IDLE, RUN, DONE
  - the DATA_W constant
- No sub-module. The FP ALU is instantiated in the parent and connected through the alu_* ports.

## Test plan
- Add, A={1.0,2.0,3.0,4.0} (3F800000,40000000,40400000,40800000), B=all 1.0 → rsp_vec={40000000,40400000,40800000,40A00000}, mask=0, rsp_valid 4 cycles after accept.
- Compare, A={1.0,4.0,2.0,8.0}, B={2.0,3.0,2.0,1.0} → rsp_mask=4'b1010, rsp_vec=B.
- Backpressure: hold rsp_ready=0 for 5 cycles in DONE → rsp_vec/rsp_mask stable, req_ready=0, a new req_valid is not accepted. Release → IDLE next cycle and the next request is accepted.
- Assert rst after 2 lanes of a mul → all outputs 0 immediately. Then mul A={2.0…}, B={3.0…} → all lanes 40C00000.
- FP_SEQ_REDUCE_EN build: reduce mul, A={1.0,2.0,3.0,4.0} → lane0=41C00000 (24.0) after 3 RUN cycles, other lanes 0.
- Sub with A=B={5.0 ×4} → all lanes 00000000. alu_op=01 seen only during the 4 RUN cycles.
